// File: rtl/hash_pkg.sv
// hash_pkg: shared types and helpers for the hash result path.
//   core_idx_t   : core index wide enough for the largest supported array (16)
//   result_t     : {core, nonce} record as handed to the result transmitter
//   lead_zero_ok : checks that the top d bits of a left-aligned hash are zero
package hash_pkg;

  localparam int MAX_CORES   = 16;
  localparam int CORE_IDX_W  = 4;
  localparam int MAX_HASH_W  = 256;
  localparam int MAX_NONCE_W = 64;

  typedef logic [CORE_IDX_W-1:0] core_idx_t;

  typedef struct packed {
    core_idx_t               core;
    logic [MAX_NONCE_W-1:0]  nonce;
  } result_t;

  // hash must be left-aligned in MAX_HASH_W bits; d is already clamped by the
  // caller to the real hash width, so d == 0 always passes.
  function automatic logic lead_zero_ok(input logic [MAX_HASH_W-1:0] hash,
                                        input int unsigned d);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < MAX_HASH_W; i++) begin
      if (i < d && hash[MAX_HASH_W-1-i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write request/data (ignored when full unless popping)
//   pop             : remove head (ignored when empty)
//   pop_data        : head entry, reads 0 while empty
//   full, empty     : occupancy flags, derived from registered state only
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Tiny storage: read asynchronously so the head falls through without a
  // bubble; the data itself is not reset, the empty flag masks it instead.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);

  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/hash_result_collector.sv
// hash_result_collector: watches NUM_CORES SHA cores, latches each core's
// nonce at CAPTURE_COUNT, tests finished hashes against a runtime difficulty
// and queues winning {core, nonce} pairs for the result transmitter.
//   clk, rst           : clock, synchronous active-high reset
//   count, nonce       : per-core round counter and current nonce (slice i)
//   hash_valid/msw     : per-core final-hash strobe and top HASH_W hash bits
//   difficulty         : required leading zero bits (clamped to HASH_W)
//   res_valid/ready    : valid/ready handshake for the head result
//   res_core/res_nonce : head result contents (0 when empty)
//   overflow           : sticky, a hit was dropped; clear_overflow clears it
//   hit_count          : hits accepted into pending registers (wraps)
module hash_result_collector
  import hash_pkg::*;
#(
  parameter int NUM_CORES     = 4,
  parameter int HASH_W        = 32,
  parameter int NONCE_W       = 32,
  parameter int COUNT_W       = 6,
  parameter int CAPTURE_COUNT = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CORES*COUNT_W-1:0]        count,
  input  logic [NUM_CORES*NONCE_W-1:0]        nonce,
  input  logic [NUM_CORES-1:0]                hash_valid,
  input  logic [NUM_CORES*HASH_W-1:0]         hash_msw,
  input  logic [$clog2(HASH_W+1)-1:0]         difficulty,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] res_core,
  output logic [NONCE_W-1:0]                  res_nonce,
  output logic                                overflow,
  input  logic                                clear_overflow,
  output logic [15:0]                         hit_count
);

  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int DIFF_W = $clog2(HASH_W+1);
  localparam int RES_W  = CORE_W + NONCE_W;

  logic [NONCE_W-1:0]    nonce_stored_reg [NUM_CORES];
  logic [NONCE_W-1:0]    pnonce_reg       [NUM_CORES];
  logic [NUM_CORES-1:0]  pending_reg;
  core_idx_t             rr_ptr_reg;
  logic                  overflow_reg;
  logic [15:0]           hit_count_reg;

  logic [MAX_HASH_W-1:0] hash_ext [NUM_CORES];
  logic [DIFF_W-1:0]     diff_eff;
  logic [NUM_CORES-1:0]  pass;
  logic [NUM_CORES-1:0]  accept;
  logic [NUM_CORES-1:0]  drop;
  logic [NUM_CORES-1:0]  granted;
  logic [MAX_CORES-1:0]  pend_pad;

  logic                  grant_valid;
  core_idx_t             grant_idx;
  logic [NONCE_W-1:0]    grant_nonce;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [RES_W-1:0]      fifo_wdata;
  logic [RES_W-1:0]      fifo_rdata;

  assign diff_eff = (int'(difficulty) > HASH_W) ? DIFF_W'(HASH_W) : difficulty;

  // Per-core capture, hit test and pending slot.
  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign hash_ext[gi] = MAX_HASH_W'(hash_msw[gi*HASH_W +: HASH_W]) << (MAX_HASH_W - HASH_W);
      assign pass[gi]     = hash_valid[gi] && lead_zero_ok(hash_ext[gi], 32'(diff_eff));
      assign granted[gi]  = grant_valid && (grant_idx == core_idx_t'(gi));
      // A slot being granted this edge is free again, so it can take a new hit.
      assign accept[gi]   = pass[gi] && (!pending_reg[gi] || granted[gi]);
      assign drop[gi]     = pass[gi] && pending_reg[gi] && !granted[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          nonce_stored_reg[gi] <= '0;
        end else if (count[gi*COUNT_W +: COUNT_W] == COUNT_W'(CAPTURE_COUNT)) begin
          nonce_stored_reg[gi] <= nonce[gi*NONCE_W +: NONCE_W];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          pending_reg[gi] <= 1'b0;
          pnonce_reg[gi]  <= '0;
        end else if (accept[gi]) begin
          pending_reg[gi] <= 1'b1;
          pnonce_reg[gi]  <= nonce_stored_reg[gi];
        end else if (granted[gi]) begin
          pending_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign pend_pad = MAX_CORES'(pending_reg);

  // Round-robin arbiter: first pending core at or after rr_ptr, one grant per
  // cycle, only if the FIFO has room now or frees a slot on this edge.
  always_comb begin
    int        s;
    core_idx_t idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    s           = 0;
    idx         = '0;
    if (!fifo_full || fifo_pop) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        s = int'(rr_ptr_reg) + k;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        idx = core_idx_t'(s);
        if (!grant_valid && pend_pad[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = idx;
        end
      end
    end
  end

  always_comb begin
    grant_nonce = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (granted[k]) grant_nonce = pnonce_reg[k];
    end
  end

  assign fifo_wdata = {grant_idx[CORE_W-1:0], grant_nonce};
  assign fifo_pop   = !fifo_empty && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      hit_count_reg <= '0;
    end else begin
      if (grant_valid) begin
        if (grant_idx == core_idx_t'(NUM_CORES-1)) rr_ptr_reg <= '0;
        else                                       rr_ptr_reg <= grant_idx + 1'b1;
      end
      // A drop in the same cycle as a clear must stay visible.
      if (|drop)               overflow_reg <= 1'b1;
      else if (clear_overflow) overflow_reg <= 1'b0;
      hit_count_reg <= hit_count_reg + 16'($countones(accept));
    end
  end

  sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_valid),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign res_valid = !fifo_empty;
  assign res_core  = fifo_rdata[RES_W-1 -: CORE_W];
  assign res_nonce = fifo_rdata[NONCE_W-1:0];
  assign overflow  = overflow_reg;
  assign hit_count = hit_count_reg;

endmodule

// File: tb/tb_hash_result_collector.sv
module tb_hash_result_collector;

  localparam int NC = 4;
  localparam int HW = 32;
  localparam int NW = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC*CW-1:0] count = '0;
  logic [NC*NW-1:0] nonce = '0;
  logic [NC-1:0]    hash_valid = '0;
  logic [NC*HW-1:0] hash_msw = '0;
  logic [5:0]       difficulty = 6'd32;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [1:0]       res_core;
  logic [NW-1:0]    res_nonce;
  logic             overflow;
  logic             clear_overflow = 1'b0;
  logic [15:0]      hit_count;

  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q[$];

  hash_result_collector #(
    .NUM_CORES(NC), .HASH_W(HW), .NONCE_W(NW), .COUNT_W(CW),
    .CAPTURE_COUNT(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .count(count), .nonce(nonce),
    .hash_valid(hash_valid), .hash_msw(hash_msw), .difficulty(difficulty),
    .res_valid(res_valid), .res_ready(res_ready), .res_core(res_core),
    .res_nonce(res_nonce), .overflow(overflow),
    .clear_overflow(clear_overflow), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted transfer is compared with the oldest expectation.
  always @(negedge clk) begin : mon
    logic [35:0] e;
    if (!rst && res_valid && res_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got core=%0d nonce=%h, required no result", res_core, res_nonce);
      end else begin
        e = exp_q.pop_front();
        $display("pop core=%0d nonce=%h (exp core=%0d nonce=%h)", res_core, res_nonce, e[35:32], e[31:0]);
        if (32'(res_core) !== 32'(e[35:32]) || res_nonce !== e[31:0]) begin
          bad++;
          $display("FAIL result_order: got core=%0d nonce=%h, required core=%0d nonce=%h",
                   res_core, res_nonce, e[35:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; hash_valid = '0; count = '0; clear_overflow = 1'b0; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_core(input int c, input logic [5:0] cnt, input logic [31:0] n);
    count[c*CW +: CW] = cnt;
    nonce[c*NW +: NW] = n;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: left=%0d res_valid=%b, required 0 left and res_valid=0", name, exp_q.size(), res_valid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (res_valid !== 1'b0 || res_core !== 2'd0 || res_nonce !== 32'd0 ||
        overflow !== 1'b0 || hit_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b core=%0d nonce=%h ovf=%b hits=%0d, required all 0",
               res_valid, res_core, res_nonce, overflow, hit_count);
    end
  endtask

  task automatic test_capture_hit();
    apply_reset();
    difficulty = 6'd32;
    set_core(2, 6'd1, 32'hDEADBEEF);
    tick();
    count = '0;
    nonce = '0;
    hash_valid[2] = 1'b1;
    hash_msw[2*HW +: HW] = 32'h0;
    exp_q.push_back({4'd2, 32'hDEADBEEF});
    tick();  // edge t: pending set
    hash_valid = '0;
    total++;
    if (res_valid !== 1'b0 || hit_count !== 16'd1) begin
      bad++;
      $display("FAIL cap_pending: valid=%b hits=%0d, required valid=0 hits=1", res_valid, hit_count);
    end
    tick();  // edge t+1: written to FIFO
    total++;
    if (res_valid !== 1'b1 || res_core !== 2'd2 || res_nonce !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL cap_latency: valid=%b core=%0d nonce=%h, required valid=1 core=2 nonce=deadbeef",
               res_valid, res_core, res_nonce);
    end
    res_ready = 1'b1;
    wait_drain("capture");
  endtask

  task automatic do_hit(input int c, input logic [31:0] h, input logic [5:0] d, input bit expect_hit);
    difficulty = d;
    hash_valid[c] = 1'b1;
    hash_msw[c*HW +: HW] = h;
    if (expect_hit) exp_q.push_back({4'(c), 32'h1234_5678});
    tick();
    hash_valid = '0;
  endtask

  task automatic test_difficulty();
    logic [15:0] base;
    res_ready = 1'b1;
    set_core(1, 6'd1, 32'h1234_5678);
    tick();
    count = '0;
    base = hit_count;
    do_hit(1, 32'h0000_FFFF, 6'd16, 1'b1);
    do_hit(1, 32'h0000_FFFF, 6'd17, 1'b0);
    do_hit(1, 32'hFFFF_FFFF, 6'd0,  1'b1);
    do_hit(1, 32'h0000_0000, 6'd40, 1'b1);
    do_hit(1, 32'h0000_0001, 6'd32, 1'b0);
    wait_drain("difficulty");
    total++;
    if (hit_count !== base + 16'd3 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL difficulty_hits: hits=%0d ovf=%b, required hits=%0d ovf=0", hit_count, overflow, base + 16'd3);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    res_ready = 1'b1;
    difficulty = 6'd32;
    for (int k = 0; k < NC; k++) set_core(k, 6'd1, 32'hC0DE_0000 + 32'(k));
    tick();
    count = '0;
    hash_valid = '1;
    hash_msw = '0;
    for (int k = 0; k < NC; k++) exp_q.push_back({4'(k), 32'hC0DE_0000 + 32'(k)});
    tick();
    hash_valid = '0;
    tick();
    for (int k = 0; k < NC; k++) begin
      total++;
      if (res_valid !== 1'b1 || 32'(res_core) !== 32'(k)) begin
        bad++;
        $display("FAIL contention_order: valid=%b core=%0d, required valid=1 core=%0d", res_valid, res_core, k);
      end
      tick();
    end
    total++;
    if (res_valid !== 1'b0 || overflow !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL contention_end: valid=%b ovf=%b left=%0d, required 0 0 0", res_valid, overflow, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    difficulty = 6'd32;
    hash_msw = '0;
    set_core(0, 6'd1, 32'hA000_0000);
    tick();
    for (int k = 1; k <= 6; k++) begin
      hash_valid[0] = 1'b1;
      set_core(0, 6'd1, 32'hA000_0000 + 32'(k));
      if (k <= 5) exp_q.push_back({4'd0, 32'hA000_0000 + 32'(k - 1)});
      tick();
    end
    hash_valid = '0;
    count = '0;
    total++;
    if (overflow !== 1'b1 || hit_count !== 16'd5 || res_valid !== 1'b1 || res_nonce !== 32'hA000_0000) begin
      bad++;
      $display("FAIL overflow_state: ovf=%b hits=%0d valid=%b head=%h, required ovf=1 hits=5 valid=1 head=a0000000",
               overflow, hit_count, res_valid, res_nonce);
    end
    res_ready = 1'b1;
    wait_drain("overflow");
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: ovf=%b, required 1", overflow);
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear: ovf=%b, required 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    difficulty = 6'd32;
    hash_msw = '0;
    set_core(0, 6'd1, 32'hB000_0000);
    tick();
    for (int k = 1; k <= 5; k++) begin
      hash_valid[0] = 1'b1;
      set_core(0, 6'd1, 32'hB000_0000 + 32'(k));
      exp_q.push_back({4'd0, 32'hB000_0000 + 32'(k - 1)});
      tick();
    end
    hash_valid = '0;
    count = '0;
    tick();
    total++;
    if (res_valid !== 1'b1 || overflow !== 1'b0 || hit_count !== 16'd5) begin
      bad++;
      $display("FAIL full_setup: valid=%b ovf=%b hits=%0d, required 1 0 5", res_valid, overflow, hit_count);
    end
    // Full FIFO plus pending entry: pop, grant and a fresh hit on one edge.
    res_ready = 1'b1;
    hash_valid[0] = 1'b1;
    exp_q.push_back({4'd0, 32'hB000_0005});
    tick();
    hash_valid = '0;
    res_ready = 1'b0;
    tick();
    tick();
    total++;
    if (overflow !== 1'b0 || hit_count !== 16'd6) begin
      bad++;
      $display("FAIL full_pop_push: ovf=%b hits=%0d, required ovf=0 hits=6", overflow, hit_count);
    end
    res_ready = 1'b1;
    wait_drain("full_pop");
  endtask

  task automatic test_reset_mid();
    bit seen;
    apply_reset();
    difficulty = 6'd32;
    hash_msw = '0;
    set_core(0, 6'd1, 32'hE000_0000);
    set_core(1, 6'd1, 32'hE100_0000);
    tick();
    count = '0;
    for (int k = 1; k <= 4; k++) begin
      hash_valid[0] = 1'b1;
      hash_valid[1] = (k == 4);
      tick();
    end
    hash_valid = '0;
    total++;
    if (hit_count !== 16'd5 || res_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_setup: hits=%0d valid=%b, required hits=5 valid=1", hit_count, res_valid);
    end
    rst = 1'b1;
    tick();
    total++;
    if (res_valid !== 1'b0 || hit_count !== 16'd0 || overflow !== 1'b0 || res_nonce !== 32'd0) begin
      bad++;
      $display("FAIL midrst_state: valid=%b hits=%0d ovf=%b nonce=%h, required all 0",
               res_valid, hit_count, overflow, res_nonce);
    end
    rst = 1'b0;
    exp_q.delete();
    res_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || hit_count !== 16'd0) begin
      bad++;
      $display("FAIL midrst_stale: stale_seen=%b hits=%0d, required 0 0", seen, hit_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_capture_hit();
    test_difficulty();
    test_contention();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hash_result_collector.md
Name: hash_result_collector

Overview:
- Parametrised successor to the single-channel hash checker. It monitors NUM_CORES SHA cores, captures each core's nonce at a programmable round count, and tests each finished hash's leading bits against a runtime difficulty.
- Winning {core, nonce} pairs are queued in a small FIFO behind a valid/ready interface to the host/UART side.
- It sits between the SHA core array and the result transmitter.

Parameters:
- NUM_CORES, 4, number of monitored SHA cores (1..16)
- HASH_W, 32, number of most-significant hash bits presented per core
- NONCE_W, 32, nonce width
- COUNT_W, 6, width of each core's round counter
- CAPTURE_COUNT, 1, round-count value at which a core's nonce is latched
- FIFO_DEPTH, 4, result FIFO entries (power of 2, at least 2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- count  in  NUM_CORES*COUNT_W  per-core round counter; core i occupies slice i
- nonce  in  NUM_CORES*NONCE_W  per-core nonce currently being hashed
- hash_valid  in  NUM_CORES  per-core one-cycle strobe: hash_msw slice is final
- hash_msw  in  NUM_CORES*HASH_W  per-core top HASH_W bits of the final hash
- difficulty  in  $clog2(HASH_W+1)  required number of leading zero bits
- res_valid  out  1  FIFO non-empty
- res_ready  in  1  consumer accepts head entry when res_valid and res_ready are both high
- res_core  out  max(1,$clog2(NUM_CORES))  core index of the head entry
- res_nonce  out  NONCE_W  nonce of the head entry
- overflow  out  1  sticky: a hit was dropped
- clear_overflow  in  1  clears overflow
- hit_count  out  16  total hits accepted into pending registers; wraps at 16'hFFFF->0

Behaviour:
- Reset (rst high at a clock edge):
  - All stored nonces, pending flags, FIFO pointers, round-robin pointer, overflow and hit_count go to 0.
  - res_valid=0; res_core and res_nonce read 0.
  - An in-flight pending hit or FIFO content is discarded.
- Nonce capture, per core i: when count_i == CAPTURE_COUNT, nonce_stored_i <= nonce_i; otherwise it holds its value.
- Hit test, purely combinational on the current inputs:
  - pass_i = hash_valid_i AND (top d bits of hash_msw_i all zero), with d = min(difficulty, HASH_W).
  - d = 0 makes every valid hash pass.
  - If hash_valid_i and a capture coincide on the same core, the hit uses the previously stored nonce (register semantics).
- Pending stage: one entry per core, {pending_i, pnonce_i}.
  - pass_i at edge t sets pending_i=1 and pnonce_i=nonce_stored_i; hit_count increments by 1.
  - If pending_i is already 1 and not granted in that same cycle, the new hit is dropped, overflow <= 1, and hit_count is unchanged.
  - If pending_i is granted in the same cycle as a new pass_i, the new hit is accepted: pending stays 1 and carries the new nonce.
- Arbiter:
  - At most one grant per cycle, and only when the FIFO is not full.
  - Round-robin: search starts at rr_ptr. After a grant to core g, rr_ptr <= g+1 mod NUM_CORES.
  - The granted core's pending flag clears; {g, pnonce_g} is written to the FIFO.
- FIFO:
  - FIFO_DEPTH entries, first-word-fall-through; res_* show the head entry.
  - Pop on res_valid and res_ready.
  - A simultaneous push and pop is legal at any occupancy, including full, where the grant is allowed only if a pop occurs in the same cycle.
  - A pop when empty is ignored.
- Latency: a hit at edge t sets pending, is granted and written at edge t+1, and gives res_valid=1 in cycle t+2. This holds for an empty FIFO, no contention and a non-full FIFO.
- Overflow: set on any drop. clear_overflow clears it. If a set and a clear occur in the same cycle, the set wins.
- Outputs are registered. There are no combinational paths from inputs to res_valid, overflow or hit_count.

Decomposition:
- Package hash_pkg:
  - core_idx_t width constant
  - result_t struct {core, nonce}
  - function lead_zero_ok(hash, d)
- Sub-module sync_fifo, parametrised on WIDTH and DEPTH with FWFT, reused elsewhere in the codebase.
- The arbiter stays inline.

Test Plan:
- Capture/hit: CAPTURE_COUNT=1, core 2 count=1 with nonce=32'hDEADBEEF, later hash_valid with hash_msw=0 and difficulty=32 -> res_valid at t+2 with res_core=2, res_nonce=32'hDEADBEEF; hit_count=1.
- Difficulty boundary:
  - hash_msw=32'h0000_FFFF with difficulty=16 -> hit.
  - hash_msw=32'h0000_FFFF with difficulty=17 -> no hit.
  - difficulty=0 with hash_msw=32'hFFFF_FFFF -> hit.
- Contention: all 4 cores pass in the same cycle with res_ready=1 -> results in core order 0,1,2,3 on consecutive cycles; overflow=0.
- Backpressure/overflow:
  - res_ready=0 while core 0 hits 6 times -> FIFO holds 4 entries and one is pending.
  - The 6th hit sets overflow=1 and hit_count=5.
  - Raising res_ready drains 5 entries in order.
  - clear_overflow -> overflow=0.
- Full with simultaneous pop: FIFO full, res_ready=1 and a pending hit present -> push and pop in the same cycle; occupancy stays 4 and no entry is lost.
- Reset mid-operation: rst asserted with 3 FIFO entries and 2 pending -> next cycle res_valid=0, hit_count=0, overflow=0; no stale result appears after rst deasserts.
